serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor with borrow-in: computes a - b - bin one bit per clock, LSB first, through a single full-subtractor cell.
- Complements the combinational parallel adder: same operand widths, inverse operation, multi-cycle.
- Valid/ready handshake on both sides so it can sit between stimulus/operand sources and result consumers in the arithmetic datapath.

Parameters:
- WIDTH, 4, operand and difference width in bits (>= 2).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow-in
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- diff  output  WIDTH  difference
- bout  output  1  borrow-out
- out_valid  output  1  diff/bout valid
- out_ready  input  1  consumer accepts result

Behaviour:
- One clock (clk). Reset is rst: asynchronous assert, active-high. While rst=1: state=IDLE, diff=0, bout=0, out_valid=0, in_ready=1, internal shift registers, bit counter and borrow cleared.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1: capture a, b and bin into internal registers; clear the bit counter; go to BUSY.
- BUSY:
  - in_ready=0, out_valid=0.
  - Each edge processes bit i = counter: d_i = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br). The initial br is the captured bin.
  - The result bit shifts into the difference register from the MSB end, so after WIDTH shifts the LSB is at bit 0. The counter increments.
  - On the edge that processes bit WIDTH-1: go to DONE and update diff and bout.
- DONE:
  - out_valid=1, in_ready=0.
  - Hold diff, bout and out_valid stable while out_ready=0; no length limit on backpressure.
  - On an edge with out_ready=1: go to IDLE. in_ready=1 from the next cycle.
- Latency: operands captured at edge E0; out_valid visible after edge E0+WIDTH (WIDTH cycles). Throughput is at most one result per WIDTH+2 cycles.
- Arithmetic:
  - diff = (a - b - bin) mod 2^WIDTH.
  - bout = 1 iff a < b + bin (unsigned; b + bin evaluated at WIDTH+1 bits).
- diff and bout:
  - Hold the last result after the handshake, until the next result or reset.
  - The internal partial result is not visible on diff during BUSY.
- in_valid outside IDLE is ignored; operands are not queued.
- The a, b and bin inputs may change freely after capture.
- A single in_valid/out_ready handshake in the same cycle cannot occur (in_ready and out_valid are mutually exclusive).
- Reset mid-BUSY or mid-DONE aborts the operation; the result is discarded and all outputs return to reset values.
- All outputs are registered.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), reset 0.
  - Signed two's-complement overflow of a - b - bin: ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]).
  - ovf updates with diff and holds with it.
- Undefined: port absent, no extra logic.

Test Plan:
- Reset: assert rst mid-cycle (asynchronous) -> immediately diff=0000, bout=0, out_valid=0, in_ready=1.
- a=1001, b=0011, bin=0, in_valid one cycle -> out_valid rises exactly 4 cycles after the capture edge, diff=0110, bout=0; with out_ready=1 -> back to IDLE, in_ready=1 the next cycle.
- a=0011, b=1001, bin=1 -> diff=1001, bout=1.
- a=0000, b=0000, bin=1 -> diff=1111, bout=1. a=1111, b=1111, bin=0 -> diff=0000, bout=0.
- Backpressure: result a=1010, b=0101, bin=0 (diff=0101) with out_ready=0 for 6 cycles; in_valid=1 with new operands meanwhile -> diff and out_valid stable, in_ready=0, new operands ignored. Then out_ready=1 -> IDLE; the next in_valid is accepted.
- Reset mid-BUSY (2 bits processed) -> IDLE, outputs 0, no out_valid. The next operation a=0111, b=0001 gives diff=0110. With SERIAL_SUBTRACTOR_OVF_EN: a=1000, b=0001, bin=0 -> diff=0111, bout=0, ovf=1.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor computing a - b - bin LSB first, with valid/ready handshakes.
// Optional signed overflow output is enabled by defining SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             out_valid,
  input  logic             out_ready
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-2:0] acc;
  logic [CW-1:0]    cnt;
  logic             br;

  logic             a_bit;
  logic             b_bit;
  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] shifted;

  // Single full-subtractor cell on the current bit.
  always_comb begin
    a_bit   = a_reg[cnt];
    b_bit   = b_reg[cnt];
    d_bit   = a_bit ^ b_bit ^ br;
    br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
    shifted = {d_bit, acc};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      cnt       <= '0;
      br        <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= a;
            b_reg    <= b;
            br       <= bin;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          // acc holds the low WIDTH-1 result bits; the final bit completes diff directly.
          acc <= shifted[WIDTH-1:1];
          br  <= br_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            diff      <= shifted;
            bout      <= br_next;
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf       <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (d_bit != a_reg[WIDTH-1]);
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=4), hand-computed vectors.
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       bin;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] diff;
  logic       bout;
  logic       out_valid;
  logic       out_ready;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic       ovf;
`endif

  int tests;
  int fails;

  serial_subtractor #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .diff      (diff),
    .bout      (bout),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operand set, then count edges after capture until out_valid.
  task automatic do_op(input logic [3:0] ai, input logic [3:0] bi, input logic bi_n,
                       output int lat, output logic [3:0] d, output logic bo, output logic ov);
    @(negedge clk);
    a = ai; b = bi; bin = bi_n; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 4'hx; b = 4'hx; bin = 1'bx;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
    d  = diff;
    bo = bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ov = ovf;
`else
    ov = 1'b0;
`endif
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    int lat; logic [3:0] d; logic bo, ov;
    tests++;
    if (!(in_ready === 1'b1 && out_valid === 1'b0 && diff === 4'h0 && bout === 1'b0)) begin
      fails++;
      $display("FAIL reset_initial: in_ready=%b out_valid=%b diff=%b bout=%b, want 1 0 0000 0",
               in_ready, out_valid, diff, bout);
    end
    // Async reset while a result is waiting in DONE.
    do_op(4'b1001, 4'b0011, 1'b0, lat, d, bo, ov);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (!(in_ready === 1'b1 && out_valid === 1'b0 && diff === 4'h0 && bout === 1'b0)) begin
      fails++;
      $display("FAIL reset_async_done: in_ready=%b out_valid=%b diff=%b bout=%b, want 1 0 0000 0",
               in_ready, out_valid, diff, bout);
    end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    tests++;
    if (ovf !== 1'b0) begin
      fails++;
      $display("FAIL reset_ovf: got %b want 0", ovf);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat; logic [3:0] d; logic bo, ov;
    do_op(4'b1001, 4'b0011, 1'b0, lat, d, bo, ov);
    tests++;
    if (lat !== 4) begin
      fails++;
      $display("FAIL basic_latency: got %0d want 4", lat);
    end
    tests++;
    if (d !== 4'b0110 || bo !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL basic_result: diff=%b bout=%b in_ready=%b, want 0110 0 0", d, bo, in_ready);
    end
    release_result();
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 4'b0110) begin
      fails++;
      $display("FAIL basic_release: in_ready=%b out_valid=%b diff=%b, want 1 0 0110",
               in_ready, out_valid, diff);
    end
  endtask

  task automatic test_vectors();
    logic [3:0] va [5]  = '{4'b0011, 4'b0000, 4'b1111, 4'b1001, 4'b0110};
    logic [3:0] vb [5]  = '{4'b1001, 4'b0000, 4'b1111, 4'b0011, 4'b0111};
    logic       vc [5]  = '{1'b1,    1'b1,    1'b0,    1'b1,    1'b0};
    logic [3:0] ed [5]  = '{4'b1001, 4'b1111, 4'b0000, 4'b0101, 4'b1111};
    logic       eb [5]  = '{1'b1,    1'b1,    1'b0,    1'b0,    1'b1};
    logic       eo [5]  = '{1'b1,    1'b0,    1'b0,    1'b1,    1'b0};
    int lat; logic [3:0] d; logic bo, ov;
    for (int i = 0; i < 5; i++) begin
      do_op(va[i], vb[i], vc[i], lat, d, bo, ov);
      tests++;
      if (lat !== 4 || d !== ed[i] || bo !== eb[i]) begin
        fails++;
        $display("FAIL vector%0d: lat=%0d diff=%b bout=%b, want 4 %b %b", i, lat, d, bo, ed[i], eb[i]);
      end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      tests++;
      if (ov !== eo[i]) begin
        fails++;
        $display("FAIL vector%0d_ovf: got %b want %b", i, ov, eo[i]);
      end
`else
      if (eo[i] === 1'bx) $display("unexpected table entry");
`endif
      release_result();
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [3:0] d; logic bo, ov;
    int bad;
    do_op(4'b1010, 4'b0101, 1'b0, lat, d, bo, ov);
    tests++;
    if (d !== 4'b0101 || bo !== 1'b0) begin
      fails++;
      $display("FAIL bp_result: diff=%b bout=%b, want 0101 0", d, bo);
    end
    bad = 0;
    @(negedge clk);
    a = 4'b1111; b = 4'b0000; bin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== 4'b0101 || bout !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL bp_hold: %0d unstable cycles, last out_valid=%b in_ready=%b diff=%b, want 1 0 0101",
               bad, out_valid, in_ready, diff);
    end
    @(negedge clk);
    in_valid = 1'b0;
    release_result();
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 4'b0101) begin
      fails++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b diff=%b, want 1 0 0101",
               in_ready, out_valid, diff);
    end
    do_op(4'b1100, 4'b0100, 1'b0, lat, d, bo, ov);
    tests++;
    if (lat !== 4 || d !== 4'b1000 || bo !== 1'b0) begin
      fails++;
      $display("FAIL bp_next_op: lat=%0d diff=%b bout=%b, want 4 1000 0", lat, d, bo);
    end
    release_result();
  endtask

  task automatic test_reset_busy();
    int lat; logic [3:0] d; logic bo, ov;
    int seen;
    @(negedge clk);
    a = 4'b1111; b = 4'b0001; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 4'h0 || bout !== 1'b0) begin
      fails++;
      $display("FAIL rst_busy: in_ready=%b out_valid=%b diff=%b bout=%b, want 1 0 0000 0",
               in_ready, out_valid, diff, bout);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL rst_busy_no_result: out_valid high %0d cycles, want 0", seen);
    end
    do_op(4'b0111, 4'b0001, 1'b0, lat, d, bo, ov);
    tests++;
    if (lat !== 4 || d !== 4'b0110 || bo !== 1'b0) begin
      fails++;
      $display("FAIL rst_busy_next: lat=%0d diff=%b bout=%b, want 4 0110 0", lat, d, bo);
    end
    release_result();
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    do_op(4'b1000, 4'b0001, 1'b0, lat, d, bo, ov);
    tests++;
    if (d !== 4'b0111 || bo !== 1'b0 || ov !== 1'b1) begin
      fails++;
      $display("FAIL ovf_case: diff=%b bout=%b ovf=%b, want 0111 0 1", d, bo, ov);
    end
    release_result();
`endif
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    a = 4'h0; b = 4'h0; bin = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_vectors();
    test_backpressure();
    test_reset_busy();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
